// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: region default and register offsets.
// Offsets are byte offsets within the region; only bits [7:2] are decoded.
package mmio_pkg;

    localparam logic [3:0] MMIO_REGION_DFLT = 4'h8;

    localparam logic [7:0] MMIO_UART_CTRL = 8'h00;
    localparam logic [7:0] MMIO_UART_RX   = 8'h04;
    localparam logic [7:0] MMIO_UART_TX   = 8'h08;
    localparam logic [7:0] MMIO_CYCLE_CNT = 8'h10;
    localparam logic [7:0] MMIO_INST_CNT  = 8'h14;
    localparam logic [7:0] MMIO_CNT_RST   = 8'h18;

    // Word index used by the address decoder.
    function automatic logic [5:0] word_sel(input logic [7:0] off);
        return off[7:2];
    endfunction

endpackage

// File: rtl/mmio_counter.sv
// Free-running counter with increment enable and a clear that beats increment.
// Wraps modulo 2^W.
module mmio_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear (and reset) win over increment so a clear always reads back as zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO target beside dmem: UART TX/RX handshakes plus cycle and retire counters.
// Load data and hit flag are registered to line up with the dmem read path.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [3:0] MMIO_REGION = MMIO_REGION_DFLT,
    parameter int          CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic        inst_retire,
    output logic [31:0] rsp_rdata,
    output logic        rsp_hit,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam logic [5:0] SEL_CTRL = word_sel(MMIO_UART_CTRL);
    localparam logic [5:0] SEL_RX   = word_sel(MMIO_UART_RX);
    localparam logic [5:0] SEL_TX   = word_sel(MMIO_UART_TX);
    localparam logic [5:0] SEL_CYC  = word_sel(MMIO_CYCLE_CNT);
    localparam logic [5:0] SEL_INS  = word_sel(MMIO_INST_CNT);
    localparam logic [5:0] SEL_CRST = word_sel(MMIO_CNT_RST);

    logic             hit;
    logic             ld;
    logic             st;
    logic [5:0]       sel;
    logic             cnt_clr;
    logic             tx_take;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ins_cnt;
    logic [31:0]      rd_val;
    logic             unused_bits;

    assign hit = req_valid && (req_addr[31:28] == MMIO_REGION);
    assign ld  = hit && !req_we;
    assign st  = hit && req_we;
    assign sel = req_addr[7:2];

    assign cnt_clr = st && (sel == SEL_CRST) && (req_be != 4'b0000);

    // A new TX byte is accepted when the holding register is empty or being
    // drained this very cycle; otherwise the store is dropped.
    assign tx_take = st && (sel == SEL_TX) && req_be[0]
                     && (!uart_tx_valid || uart_tx_ready);

    assign uart_rx_ready = ld && (sel == SEL_RX) && !rst;

    assign unused_bits = ^{req_addr[27:8], req_addr[1:0],
                           req_wdata[31:8], req_be[3:1]};

    mmio_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .clr   (cnt_clr),
        .count (cyc_cnt)
    );

    mmio_counter #(.W(CNT_W)) u_ins_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inst_retire),
        .clr   (cnt_clr),
        .count (ins_cnt)
    );

    // Read mux: register values as seen in the request cycle.
    always_comb begin
        rd_val = 32'h0;
        case (sel)
            SEL_CTRL: rd_val = {30'b0, uart_rx_valid, ~uart_tx_valid};
            SEL_RX:   rd_val = {24'b0, uart_rx_data};
            SEL_CYC:  rd_val = 32'(cyc_cnt);
            SEL_INS:  rd_val = 32'(ins_cnt);
            default:  rd_val = 32'h0;
        endcase
    end

    // Registered load response; zero on anything but an MMIO load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= 32'h0;
            rsp_hit   <= 1'b0;
        end else begin
            rsp_rdata <= ld ? rd_val : 32'h0;
            rsp_hit   <= ld;
        end
    end

    // TX holding register: load on accept, drop valid on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h00;
        end else if (tx_take) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= req_wdata[7:0];
        end else if (uart_tx_valid && uart_tx_ready) begin
            uart_tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed plan then random traffic,
// each cycle compared against a behavioural model of the register map.
module tb_mmio_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        inst_retire;
    logic [31:0] rsp_rdata;
    logic        rsp_hit;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    int unsigned m_cyc;
    int unsigned m_ins;
    logic        m_txv;
    logic [7:0]  m_txd;
    logic [31:0] e_rd;
    logic        e_hit;

    always #5 clk = ~clk;

    mmio_responder dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_be        (req_be),
        .inst_retire   (inst_retire),
        .rsp_rdata     (rsp_rdata),
        .rsp_hit       (rsp_hit),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check the combinational pop strobe, advance the model
    // across the edge, then check all registered outputs.
    task automatic step();
        logic        hit;
        logic        isld;
        logic        isst;
        logic [7:0]  off;
        logic [31:0] val;
        logic        clr;
        logic        take;
        int unsigned n_cyc;
        int unsigned n_ins;
        logic        n_txv;
        logic [7:0]  n_txd;
        #2;
        hit  = req_valid && (req_addr[31:28] == 4'h8);
        off  = {req_addr[7:2], 2'b00};
        isld = hit && !req_we;
        isst = hit && req_we;
        check("rx_ready", {31'b0, uart_rx_ready},
              {31'b0, isld && (off == 8'h04) && !rst});
        case (off)
            8'h00:   val = {30'b0, uart_rx_valid, ~m_txv};
            8'h04:   val = {24'b0, uart_rx_data};
            8'h10:   val = m_cyc;
            8'h14:   val = m_ins;
            default: val = 32'h0;
        endcase
        clr  = isst && (off == 8'h18) && (req_be != 4'b0);
        take = isst && (off == 8'h08) && req_be[0]
               && (!m_txv || uart_tx_ready);
        if (rst) begin
            n_cyc = 0; n_ins = 0; n_txv = 1'b0; n_txd = 8'h00;
            e_rd = 32'h0; e_hit = 1'b0;
        end else begin
            n_cyc = clr ? 0 : m_cyc + 1;
            n_ins = clr ? 0 : m_ins + (inst_retire ? 1 : 0);
            n_txv = m_txv;
            n_txd = m_txd;
            if (take) begin
                n_txv = 1'b1;
                n_txd = req_wdata[7:0];
            end else if (m_txv && uart_tx_ready) begin
                n_txv = 1'b0;
            end
            e_rd  = isld ? val : 32'h0;
            e_hit = isld;
        end
        @(posedge clk);
        #1;
        m_cyc = n_cyc; m_ins = n_ins; m_txv = n_txv; m_txd = n_txd;
        check("rsp_rdata", rsp_rdata, e_rd);
        check("rsp_hit", {31'b0, rsp_hit}, {31'b0, e_hit});
        check("tx_valid", {31'b0, uart_tx_valid}, {31'b0, m_txv});
        check("tx_data", {24'b0, uart_tx_data}, {24'b0, m_txd});
    endtask

    task automatic ld(input logic [31:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        req_wdata = $urandom; req_be = 4'h0;
        step();
        req_valid = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a;
        req_wdata = d; req_be = be;
        step();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_be = 4'h0; inst_retire = 1'b0;
        uart_tx_ready = 1'b0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;
        m_cyc = 0; m_ins = 0; m_txv = 1'b0; m_txd = 8'h00;

        // Reset, with an MMIO RX load held to show the strobe is masked
        step();
        req_valid = 1'b1; req_addr = 32'h8000_0004;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b0;

        // Cycle counter: 10 idle edges after reset, then read
        repeat (10) step();
        ld(32'h8000_0010);
        check("cyc_after_10", rsp_rdata, 32'd10);
        step();
        check("hit_one_cycle", {31'b0, rsp_hit}, 32'd0);
        ld(32'h8000_0014);
        check("ins_zero", rsp_rdata, 32'd0);

        // TX held while not ready; second store dropped
        uart_tx_ready = 1'b0;
        st(32'h8000_0008, 32'h0000_0041, 4'h1);
        step(); step();
        check("tx_hold_v", {31'b0, uart_tx_valid}, 32'd1);
        check("tx_hold_d", {24'b0, uart_tx_data}, 32'h41);
        st(32'h8000_0008, 32'h0000_0042, 4'h1);
        check("tx_drop", {24'b0, uart_tx_data}, 32'h41);
        ld(32'h8000_0000);
        check("status_busy", rsp_rdata & 32'h1, 32'h0);
        uart_tx_ready = 1'b1;
        step();
        uart_tx_ready = 1'b0;
        check("tx_drained", {31'b0, uart_tx_valid}, 32'd0);
        ld(32'h8000_0000);
        check("status_free", rsp_rdata & 32'h1, 32'h1);

        // Store in the handshake cycle replaces the byte
        st(32'h8000_0008, 32'h0000_0033, 4'h1);
        uart_tx_ready = 1'b1;
        st(32'h8000_0008, 32'h0000_0055, 4'h1);
        check("tx_swap_v", {31'b0, uart_tx_valid}, 32'd1);
        check("tx_swap_d", {24'b0, uart_tx_data}, 32'h55);
        step();
        uart_tx_ready = 1'b0;

        // RX status and pop
        uart_rx_valid = 1'b1; uart_rx_data = 8'hA5;
        ld(32'h8000_0000);
        check("status_rx", rsp_rdata, 32'h3);
        ld(32'h8000_0004);
        check("rx_byte", rsp_rdata, 32'h0000_00A5);
        uart_rx_valid = 1'b0;

        // Retire 7, then clear in a retire cycle
        inst_retire = 1'b1;
        repeat (7) step();
        st(32'h8000_0018, 32'h0, 4'hF);
        inst_retire = 1'b0;
        ld(32'h8000_0010);
        check("cyc_clr", rsp_rdata, 32'd0);
        ld(32'h8000_0010);
        check("cyc_resume", rsp_rdata, 32'd1);
        ld(32'h8000_0014);
        check("ins_clr", rsp_rdata, 32'd0);

        // Non-MMIO and unmapped loads
        ld(32'h0000_0010);
        check("nonmmio_hit", {31'b0, rsp_hit}, 32'd0);
        ld(32'h8000_0020);
        check("unmapped_hit", {31'b0, rsp_hit}, 32'd1);
        check("unmapped_rd", rsp_rdata, 32'd0);

        // Reset discards a pending TX byte
        st(32'h8000_0008, 32'h0000_0099, 4'h1);
        rst = 1'b1;
        step();
        check("rst_tx", {31'b0, uart_tx_valid}, 32'd0);
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] reg_hi;
            reg_hi = ($urandom_range(0, 3) != 0) ? 4'h8 : 4'($urandom);
            req_valid     = ($urandom_range(0, 3) != 0);
            req_we        = $urandom_range(0, 1);
            req_addr      = {reg_hi, 20'($urandom),
                             6'($urandom_range(0, 9)), 2'($urandom)};
            req_wdata     = $urandom;
            req_be        = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            inst_retire   = $urandom_range(0, 1);
            uart_tx_ready = ($urandom_range(0, 2) == 0);
            uart_rx_valid = $urandom_range(0, 1);
            uart_rx_data  = 8'($urandom);
            rst           = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; req_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
